// File: rtl/pulse_stim_gen_if.sv
// Handshake and configuration bundle between the test sequencer (master)
// and the pulse stimulus generator (slave).
interface pulse_stim_gen_if #(
    parameter int CW = 8,
    parameter int RW = 8
);
    logic          start;
    logic          abort;
    logic [CW-1:0] cfg_a_delay;
    logic [CW-1:0] cfg_a_width;
    logic [CW-1:0] cfg_b_delay;
    logic [CW-1:0] cfg_b_width;
    logic [CW-1:0] cfg_period;
    logic [RW-1:0] cfg_repeat;
    logic          a;
    logic          b;
    logic          busy;
    logic          done;
    logic [RW-1:0] pulse_cnt;

    modport master (
        output start, abort,
        output cfg_a_delay, cfg_a_width, cfg_b_delay, cfg_b_width,
        output cfg_period, cfg_repeat,
        input  a, b, busy, done, pulse_cnt
    );

    modport slave (
        input  start, abort,
        input  cfg_a_delay, cfg_a_width, cfg_b_delay, cfg_b_width,
        input  cfg_period, cfg_repeat,
        output a, b, busy, done, pulse_cnt
    );
endinterface

// File: rtl/pulse_stim_gen.sv
// Programmable dual pulse-train generator driving the a/b path inputs of a
// specify-block timing model; windows per period, repeated, abortable.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; pulse_cnt holds the last run's count
// S_RUN  | stepping phase 0..period-1, emitting a/b windows
// S_DONE | one-cycle done pulse, all stimulus outputs low
module pulse_stim_gen #(
    parameter int CW = 8,
    parameter int RW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    pulse_stim_gen_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        r_state;
    logic [CW-1:0] r_phase;
    logic [RW-1:0] r_cnt;
    logic [CW-1:0] r_a_delay;
    logic [CW-1:0] r_a_width;
    logic [CW-1:0] r_b_delay;
    logic [CW-1:0] r_b_width;
    logic [CW-1:0] r_period;
    logic [RW-1:0] r_repeat;
    logic          r_a;
    logic          r_b;
    logic          r_busy;
    logic          r_done;

    logic          w_last;
    logic [CW-1:0] w_phase_nxt;
    logic [RW-1:0] w_cnt_nxt;

    assign w_last      = (r_phase == r_period - CW'(1));
    assign w_phase_nxt = r_phase + CW'(1);
    assign w_cnt_nxt   = r_cnt + RW'(1);

    // Window end is formed one bit wider so delay+width never wraps.
    function automatic logic in_win(logic [CW-1:0] p, logic [CW-1:0] d, logic [CW-1:0] w);
        logic [CW:0] e;
        e = {1'b0, d} + {1'b0, w};
        return (p >= d) && ({1'b0, p} < e);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_phase   <= '0;
            r_cnt     <= '0;
            r_a_delay <= '0;
            r_a_width <= '0;
            r_b_delay <= '0;
            r_b_width <= '0;
            r_period  <= '0;
            r_repeat  <= '0;
            r_a       <= 1'b0;
            r_b       <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a_delay <= bus.cfg_a_delay;
                        r_a_width <= bus.cfg_a_width;
                        r_b_delay <= bus.cfg_b_delay;
                        r_b_width <= bus.cfg_b_width;
                        r_period  <= bus.cfg_period;
                        r_repeat  <= bus.cfg_repeat;
                        r_cnt     <= '0;
                        r_phase   <= '0;
                        if (bus.cfg_period == '0 || bus.cfg_repeat == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                            r_a     <= in_win('0, bus.cfg_a_delay, bus.cfg_a_width);
                            r_b     <= in_win('0, bus.cfg_b_delay, bus.cfg_b_width);
                        end
                    end
                end
                S_RUN: begin
                    if (w_last) begin
                        // A completed period counts even when abort lands on it.
                        r_cnt   <= w_cnt_nxt;
                        r_phase <= '0;
                        if (w_cnt_nxt == r_repeat || bus.abort) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_a     <= 1'b0;
                            r_b     <= 1'b0;
                        end else begin
                            r_a <= in_win('0, r_a_delay, r_a_width);
                            r_b <= in_win('0, r_b_delay, r_b_width);
                        end
                    end else if (bus.abort) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_a     <= 1'b0;
                        r_b     <= 1'b0;
                    end else begin
                        r_phase <= w_phase_nxt;
                        r_a     <= in_win(w_phase_nxt, r_a_delay, r_a_width);
                        r_b     <= in_win(w_phase_nxt, r_b_delay, r_b_width);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_a     <= 1'b0;
                    r_b     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a         = r_a;
    assign bus.b         = r_b;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pulse_cnt = r_cnt;
endmodule

// File: tb/tb_pulse_stim_gen.sv
// Directed bench for pulse_stim_gen: per-cycle expected {done,busy,a,b,cnt}
// vectors are queued when a run is launched and compared as the run unfolds.
module tb_pulse_stim_gen;
    typedef struct packed {
        logic       done;
        logic       busy;
        logic       a;
        logic       b;
        logic [7:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    pulse_stim_gen_if #(.CW(8), .RW(8)) bus ();

    pulse_stim_gen #(.CW(8), .RW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t mk(logic d, logic bz, logic a, logic b, int c);
        exp_t e;
        e.done = d;
        e.busy = bz;
        e.a    = a;
        e.b    = b;
        e.cnt  = 8'(c);
        return e;
    endfunction

    function automatic exp_t cur();
        return mk(bus.done, bus.busy, bus.a, bus.b, int'(bus.pulse_cnt));
    endfunction

    task automatic chk(string tag, exp_t obs, exp_t exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch a run, queue its expected trace, then compare cycle by cycle.
    // Returns at the falling edge inside the done cycle.
    task automatic do_run(string name, int ad, int aw, int bd, int bw,
                          int per, int rep, int abort_at, int junk_at);
        int   total;
        int   limit;
        int   idx;
        int   p;
        exp_t e;
        bus.cfg_a_delay = 8'(ad);
        bus.cfg_a_width = 8'(aw);
        bus.cfg_b_delay = 8'(bd);
        bus.cfg_b_width = 8'(bw);
        bus.cfg_period  = 8'(per);
        bus.cfg_repeat  = 8'(rep);
        @(negedge clk);
        bus.start = 1'b1;
        total = per * rep;
        limit = (abort_at >= 0 && abort_at < total) ? abort_at + 1 : total;
        for (int k = 0; k < limit; k++) begin
            p = k % per;
            exp_q.push_back(mk(1'b0, 1'b1,
                               (p >= ad) && (p < ad + aw),
                               (p >= bd) && (p < bd + bw),
                               k / per));
        end
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, (total == 0) ? 0 : limit / per));
        @(negedge clk);
        bus.start = 1'b0;
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("%s_c%0d", name, idx), cur(), e);
            bus.abort = (idx == abort_at);
            bus.start = (idx == junk_at);
            if (idx == junk_at) bus.cfg_period = 8'd3;
            if (exp_q.size() > 0) @(negedge clk);
            idx++;
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.cfg_a_delay = '0;
        bus.cfg_a_width = '0;
        bus.cfg_b_delay = '0;
        bus.cfg_b_width = '0;
        bus.cfg_period  = '0;
        bus.cfg_repeat  = '0;

        @(negedge clk);
        chk("reset", cur(), mk(0, 0, 0, 0, 0));
        rst_n = 1'b1;

        // abort while idle must not disturb anything
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("idle_abort0", cur(), mk(0, 0, 0, 0, 0));
        @(negedge clk);
        chk("idle_abort1", cur(), mk(0, 0, 0, 0, 0));

        do_run("basic",   2, 3,  0, 0, 10, 3, -1, -1);
        do_run("overlap", 2, 4,  3, 1,  8, 2, -1, -1);
        do_run("trunc",   3, 10, 7, 2,  5, 2, -1, -1);
        do_run("rep0",    0, 2,  0, 2,  5, 0, -1, -1);
        do_run("per0",    0, 2,  0, 2,  0, 3, -1, -1);
        do_run("abort",   1, 4,  6, 3, 10, 5, 23, -1);
        // started in the idle cycle right after the abort's done
        do_run("b2b",     1, 2,  0, 1,  4, 2, -1, -1);
        do_run("wrapab",  0, 1,  2, 1,  4, 3,  7, -1);
        do_run("ignore",  0, 2,  4, 5,  6, 2, -1,  7);

        // count stays through idle until next start
        @(negedge clk);
        chk("idle_hold", cur(), mk(0, 0, 0, 0, 2));

        // asynchronous reset in the middle of an a pulse
        bus.cfg_a_delay = 8'd2;
        bus.cfg_a_width = 8'd3;
        bus.cfg_b_delay = 8'd0;
        bus.cfg_b_width = 8'd0;
        bus.cfg_period  = 8'd10;
        bus.cfg_repeat  = 8'd3;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (13) @(negedge clk);
        chk("rst_pre", cur(), mk(0, 1, 1, 0, 1));
        #2 rst_n = 1'b0;
        #1 chk("rst_async", cur(), mk(0, 0, 0, 0, 0));
        @(negedge clk);
        chk("rst_held", cur(), mk(0, 0, 0, 0, 0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_idle0", cur(), mk(0, 0, 0, 0, 0));
        @(negedge clk);
        chk("rst_idle1", cur(), mk(0, 0, 0, 0, 0));

        do_run("post_rst", 0, 1, 1, 2, 3, 2, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pulse_stim_gen.md
# pulse_stim_gen

Cycle-accurate stimulus generator that drives the two path inputs (`a`, `b`) of a dual-output specify-block model. It produces programmable, possibly overlapping pulse trains so that pulse filtering can be exercised without hand-written waveforms. Targets are showcancelled/on-detect handling and negative-pulse detection. It sits in the bench next to the timing model and is driven by a start/abort handshake from the test sequencer.

## Interface
Parameters:
- `CW`, 8, width of delay/width/period configuration fields and phase counter
- `RW`, 8, width of repeat count and completed-period counter

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request a run; sampled only in IDLE
- `abort`  in  1  terminate a run; sampled only in RUN
- `cfg_a_delay`  in  CW  phase at which `a` rises
- `cfg_a_width`  in  CW  cycles `a` stays high per period
- `cfg_b_delay`  in  CW  phase at which `b` rises
- `cfg_b_width`  in  CW  cycles `b` stays high per period
- `cfg_period`  in  CW  cycles per period
- `cfg_repeat`  in  RW  number of periods per run
- `a`  out  1  stimulus to path input a
- `b`  out  1  stimulus to path input b
- `busy`  out  1  high while in RUN
- `done`  out  1  one-cycle pulse at end of run (normal or aborted)
- `pulse_cnt`  out  RW  completed periods in current/last run

## Operation
- States: IDLE, RUN, DONE.
- Reset (async, `rst_n`=0): state=IDLE. `a`=`b`=`busy`=`done`=0. `pulse_cnt`=0. Phase counter=0. Config shadow registers=0.
- IDLE, `start`=1 at an edge: all `cfg_*` latched into shadow registers, `pulse_cnt`←0.
  - If latched period==0 or repeat==0: go to DONE, no pulses emitted.
  - Otherwise go to RUN with phase=0.
- RUN, phase p in 0..period-1:
  - `a`=1 iff a_delay ≤ p < a_delay+a_width.
  - `b`=1 iff b_delay ≤ p < b_delay+b_width.
  - Sums are evaluated in CW+1 bits, so there is no wrap.
  - Windows extending past period-1 are truncated. Pulses never straddle a period boundary.
  - Width 0 means the output is never high. Delay ≥ period also means never high.
  - Windows of `a` and `b` may overlap arbitrarily. This is the intended means of placing a `b` edge inside an in-flight `a` transition.
- Phase p=period-1 at an edge: phase←0 and `pulse_cnt`←`pulse_cnt`+1. If the new count equals repeat, go to DONE.
- RUN, `abort`=1 at an edge: go to DONE. `pulse_cnt` holds (partial period not counted).
- DONE (one cycle): `done`=1, `busy`=0, `a`=`b`=0. Next edge goes to IDLE.
- `start` outside IDLE is ignored. `abort` outside RUN is ignored.
- Simultaneous wrap-to-final and `abort`: the count increments (period completed), then DONE.
- `cfg_*` changes during RUN have no effect until the next accepted `start`.
- Reset asserted mid-run: outputs go to 0 immediately (asynchronous) and no `done` is issued.

## Timing
- All outputs are registered; none combinational from inputs.
- Edge E0 samples `start` in IDLE. Cycle after E0 is RUN phase 0, with `busy`=1. With a_delay=0 and a_width>0, `a`=1 in that same cycle.
- `busy` is high for exactly period×repeat cycles on a normal run.
- `done` is high in the cycle immediately after the last RUN cycle. `busy` is 0 in that cycle.
- Degenerate run (period or repeat 0): `done` is high in the cycle after E0, and `busy` never rises.
- Abort sampled at edge Ek: from the cycle after Ek, `a`=`b`=`busy`=0 and `done`=1.
- Minimum spacing between runs: one IDLE cycle after DONE. `start` is accepted in the cycle following `done`.
- `pulse_cnt` updates on the edge ending each period. It is stable through DONE and IDLE until the next `start`.

## Test plan
- Basic train:
  - Stimulus: period=10, repeat=3, a_delay=2, a_width=3, b width 0.
  - Response: `a` high at phases 2–4 of each period, i.e. RUN cycles 2–4, 12–14, 22–24. `busy` high 30 cycles, `done` at cycle 30, `pulse_cnt`=3.
- Overlap / negative-pulse setup:
  - Stimulus: a_delay=2, a_width=4, b_delay=3, b_width=1, period=8, repeat=2.
  - Response: `b` high only at phase 3, inside the `a` window at phases 2–5, in both periods.
- Truncation and zero cases:
  - Stimulus: period=5, a_delay=3, a_width=10, b_delay=7, b_width=2.
  - Response: `a` high at phases 3–4 only, `b` never high. Separately, repeat=0 gives `done` one cycle after start and `busy` never 1.
- Abort:
  - Stimulus: period=10, repeat=5, `abort` at RUN cycle 23.
  - Response: next cycle `a`=`b`=0, `done`=1, `pulse_cnt`=2. A following `start` is accepted one cycle after `done`.
- Ignored inputs:
  - Stimulus: `start` pulsed and `cfg_period` changed to 3 mid-run.
  - Response: the run continues with the original period and count. `abort` in IDLE has no effect.
- Async reset mid-run:
  - Stimulus: drop `rst_n` between edges during an `a` pulse.
  - Response: `a`, `busy` and `pulse_cnt` go to 0 without a clock edge. No `done` is issued. After release, the block is in IDLE.
